// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM with byte/half lane merging,
// zero-latency loads, and an MMIO window (LED, synchronised switches, cycle counter).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned SW_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_w,
    input  logic [31:0]     Addr_in,
    input  logic [31:0]     Data_in,
    input  logic [2:0]      dm_ctrl,
    output logic [31:0]     Data_out,
    input  logic [SW_W-1:0] sw_i,
    output logic [SW_W-1:0] led_o,
    output logic            misalign_o,
    output logic [31:0]     bad_addr_o
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned RAM_BYTES = DEPTH_WORDS * 4;

    typedef enum logic [1:0] {
        ACC_WORD,
        ACC_HALF,
        ACC_BYTE
    } acc_e;

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [SW_W-1:0] r_led;
    logic [SW_W-1:0] r_sw_s1;
    logic [SW_W-1:0] r_sw_s2;
    logic [31:0]     r_cycle;
    logic            r_misalign;
    logic [31:0]     r_bad_addr;

    acc_e            w_acc;
    logic            w_signed;
    logic            w_aligned;
    logic            w_is_ram;
    logic            w_is_mmio;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_word;
    logic [31:0]     w_bitmask;
    logic [31:0]     w_wdata;
    logic [31:0]     w_ram_merged;
    logic            w_store_ok;
    logic [15:0]     w_half;
    logic [7:0]      w_byte;

    assign w_is_ram  = (Addr_in < RAM_BYTES);
    assign w_is_mmio = (Addr_in[31:4] == 28'hFFFF000);
    assign w_idx     = Addr_in[AW+1:2];

    // Decode access width and extension from dm_ctrl; unknown codes act as word.
    always_comb begin
        w_acc    = ACC_WORD;
        w_signed = 1'b0;
        case (dm_ctrl)
            3'b001:  begin w_acc = ACC_HALF; w_signed = 1'b1; end
            3'b010:  begin w_acc = ACC_HALF; w_signed = 1'b0; end
            3'b011:  begin w_acc = ACC_BYTE; w_signed = 1'b1; end
            3'b100:  begin w_acc = ACC_BYTE; w_signed = 1'b0; end
            default: begin w_acc = ACC_WORD; w_signed = 1'b0; end
        endcase
    end

    // Alignment check, lane mask and lane-replicated write data.
    always_comb begin
        w_aligned = 1'b1;
        w_bitmask = '1;
        w_wdata   = Data_in;
        case (w_acc)
            ACC_HALF: begin
                w_aligned = (Addr_in[0] == 1'b0);
                w_bitmask = Addr_in[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wdata   = {2{Data_in[15:0]}};
            end
            ACC_BYTE: begin
                w_aligned = 1'b1;
                w_bitmask = 32'h0000_00FF << {Addr_in[1:0], 3'b000};
                w_wdata   = {4{Data_in[7:0]}};
            end
            default: begin
                w_aligned = (Addr_in[1:0] == 2'b00);
                w_bitmask = '1;
                w_wdata   = Data_in;
            end
        endcase
    end

    assign w_store_ok = mem_w && w_aligned && !reset;

    // Select the addressed word from RAM or the MMIO window; unmapped reads 0.
    always_comb begin
        w_word = '0;
        if (w_is_ram) begin
            w_word = r_mem[w_idx];
        end else if (w_is_mmio) begin
            case (Addr_in[3:2])
                2'd0:    w_word = 32'(r_led);
                2'd1:    w_word = 32'(r_sw_s2);
                2'd2:    w_word = r_cycle;
                default: w_word = '0;
            endcase
        end
    end

    assign w_ram_merged = (w_word & ~w_bitmask) | (w_wdata & w_bitmask);
    assign w_half       = Addr_in[1] ? w_word[31:16] : w_word[15:0];

    // Extract the addressed byte lane.
    always_comb begin
        w_byte = w_word[7:0];
        case (Addr_in[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    // Load data: lane extract with sign/zero extension; misaligned reads return 0.
    always_comb begin
        Data_out = '0;
        if (w_aligned) begin
            case (w_acc)
                ACC_HALF: Data_out = w_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
                ACC_BYTE: Data_out = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
                default:  Data_out = w_word;
            endcase
        end
    end

    // RAM store with lane merge; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_store_ok && w_is_ram) begin
            r_mem[w_idx] <= w_ram_merged;
        end
    end

    // LED register: same lane merge on the low SW_W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_store_ok && w_is_mmio && (Addr_in[3:2] == 2'd0)) begin
            r_led <= (r_led & ~w_bitmask[SW_W-1:0]) | (w_wdata[SW_W-1:0] & w_bitmask[SW_W-1:0]);
        end
    end

    // Two-flop synchroniser for the board switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw_i;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Free-running cycle counter; an aligned store clears it and wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_store_ok && w_is_mmio && (Addr_in[3:2] == 2'd2)) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Sticky misaligned-store flag; only the first offending address is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
            r_bad_addr <= '0;
        end else if (mem_w && !w_aligned) begin
            r_misalign <= 1'b1;
            if (!r_misalign) begin
                r_bad_addr <= Addr_in;
            end
        end
    end

    assign led_o      = r_led;
    assign misalign_o = r_misalign;
    assign bad_addr_o = r_bad_addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

    localparam logic [2:0] C_W  = 3'b000;
    localparam logic [2:0] C_HS = 3'b001;
    localparam logic [2:0] C_HU = 3'b010;
    localparam logic [2:0] C_BS = 3'b011;
    localparam logic [2:0] C_BU = 3'b100;

    logic        clk;
    logic        reset;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [2:0]  dm_ctrl;
    logic [31:0] Data_out;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic        misalign_o;
    logic [31:0] bad_addr_o;

    int unsigned n_checks;
    int unsigned n_errors;

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .SW_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_w(mem_w),
        .Addr_in(Addr_in),
        .Data_in(Data_in),
        .dm_ctrl(dm_ctrl),
        .Data_out(Data_out),
        .sw_i(sw_i),
        .led_o(led_o),
        .misalign_o(misalign_o),
        .bad_addr_o(bad_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        mem_w   = 1'b1;
        Addr_in = a;
        Data_in = d;
        dm_ctrl = c;
        tick();
        mem_w   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] c);
        Addr_in = a;
        dm_ctrl = c;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset   = 1'b1;
        mem_w   = 1'b0;
        Addr_in = '0;
        Data_in = '0;
        dm_ctrl = C_W;
        sw_i    = '0;
        repeat (3) tick();

        chk("rst_led", 32'(led_o), 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        chk("rst_bad_addr", bad_addr_o, 32'h0);
        rd(32'hFFFF_0008, C_W);
        chk("rst_cycle", Data_out, 32'h0);

        // cycle counter after reset release
        reset = 1'b0;
        rd(32'hFFFF_0008, C_W);
        chk("cycle_0", Data_out, 32'd0);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("cycle_%0d", i), Data_out, 32'(i));
        end
        store(32'hFFFF_0008, 32'h1234_5678, C_W);
        rd(32'hFFFF_0008, C_W);
        chk("cycle_clr0", Data_out, 32'd0);
        tick();
        chk("cycle_clr1", Data_out, 32'd1);

        // word store and sized loads
        store(32'h10, 32'h8899_AABB, C_W);
        rd(32'h10, C_W);  chk("ld_word", Data_out, 32'h8899_AABB);
        rd(32'h11, C_BS); chk("ld_bs11", Data_out, 32'hFFFF_FFAA);
        rd(32'h11, C_BU); chk("ld_bu11", Data_out, 32'h0000_00AA);
        rd(32'h12, C_HS); chk("ld_hs12", Data_out, 32'hFFFF_8899);
        rd(32'h12, C_HU); chk("ld_hu12", Data_out, 32'h0000_8899);
        rd(32'h10, C_HU); chk("ld_hu10", Data_out, 32'h0000_AABB);
        rd(32'h13, C_BU); chk("ld_bu13", Data_out, 32'h0000_0088);

        // byte store with same-cycle load showing old data, then half store
        mem_w = 1'b1; Addr_in = 32'h13; Data_in = 32'hDEAD_BE55; dm_ctrl = C_BU;
        #1;
        chk("same_cycle_old", Data_out, 32'h0000_0088);
        tick();
        mem_w = 1'b0;
        chk("next_cycle_new", Data_out, 32'h0000_0055);
        store(32'h10, 32'hCAFE_1234, C_HU);
        rd(32'h10, C_W); chk("merge_word", Data_out, 32'h5599_1234);

        // misaligned stores
        store(32'h20, 32'hCAFE_F00D, C_W);
        store(32'h22, 32'h1111_1111, C_W);
        chk("mis_flag", 32'(misalign_o), 32'h1);
        chk("mis_addr", bad_addr_o, 32'h22);
        rd(32'h20, C_W);  chk("mis_nowrite", Data_out, 32'hCAFE_F00D);
        rd(32'h22, C_W);  chk("mis_read0", Data_out, 32'h0);
        store(32'h31, 32'h2222_2222, C_HS);
        chk("mis_flag2", 32'(misalign_o), 32'h1);
        chk("mis_addr_kept", bad_addr_o, 32'h22);
        rd(32'h20, C_W);  chk("mis_nowrite2", Data_out, 32'hCAFE_F00D);

        // reset pulse with a store attempt that must be suppressed
        reset = 1'b1;
        store(32'h10, 32'h0000_0000, C_W);
        reset = 1'b0;
        chk("rst_mis_flag", 32'(misalign_o), 32'h0);
        chk("rst_mis_addr", bad_addr_o, 32'h0);
        rd(32'h10, C_W); chk("ram_kept_rst", Data_out, 32'h5599_1234);

        // LED register
        store(32'hFFFF_0000, 32'hFFFF_ABCD, C_W);
        chk("led_word", 32'(led_o), 32'h0000_ABCD);
        rd(32'hFFFF_0000, C_W); chk("led_read", Data_out, 32'h0000_ABCD);
        store(32'hFFFF_0001, 32'h0000_0012, C_BU);
        chk("led_byte", 32'(led_o), 32'h0000_12CD);

        // switch synchroniser latency
        rd(32'hFFFF_0004, C_W);
        chk("sw_old", Data_out, 32'h0);
        sw_i = 16'h00F0;
        tick();
        chk("sw_1edge", Data_out, 32'h0);
        tick();
        chk("sw_2edge", Data_out, 32'h0000_00F0);
        store(32'hFFFF_0004, 32'h0000_0000, C_W);
        rd(32'hFFFF_0004, C_W); chk("sw_ro", Data_out, 32'h0000_00F0);

        // unmapped and reserved reads
        rd(32'h8000_0000, C_W); chk("unmapped", Data_out, 32'h0);
        rd(32'hFFFF_000C, C_W); chk("mmio_c", Data_out, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined CPU core. It takes the core's MEM-stage request (address, write data, write strobe, access-width code) and returns load data in the same cycle. It stores into a word-organised RAM with byte/halfword lane merging and exposes a small MMIO window: an LED register, synchronised switches and a free-running cycle counter. Misaligned stores are suppressed and trapped in a sticky error flag.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two; RAM byte range is 0 .. DEPTH_WORDS*4-1.
- SW_W, 16: width of switch input and LED register.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- mem_w  in  1  store strobe for the current cycle.
- Addr_in  in  32  byte address (CPU ALU result).
- Data_in  in  32  store data (CPU rs2 value).
- dm_ctrl  in  3  access width/extension: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes behave as word.
- Data_out  out  32  load data, combinational.
- sw_i  in  SW_W  asynchronous board switches.
- led_o  out  SW_W  LED register.
- misalign_o  out  1  sticky misaligned-store flag.
- bad_addr_o  out  32  address of the first misaligned store.

## Operation
- Decode:
  - RAM if Addr_in < DEPTH_WORDS*4; word index Addr_in[log2(DEPTH_WORDS)+1:2].
  - MMIO if Addr_in[31:4] == 28'hFFFF000: offset 0x0 LED (R/W), 0x4 SW (RO), 0x8 CYCLE (R, store clears). Offset 0xC reads 0.
  - Everything else is unmapped: reads 0, stores ignored.
- Alignment:
  - Word access requires Addr_in[1:0]==0.
  - Halfword access requires Addr_in[0]==0.
  - Byte access is always aligned.
- Loads:
  - Select the addressed word, then extract the lane: half at Addr_in[1]*16, byte at Addr_in[1:0]*8.
  - Sign- or zero-extend the lane per dm_ctrl.
  - A misaligned read returns 0. No flag is raised, because the core drives the address every cycle and has no read strobe.
- Stores (mem_w=1, aligned, reset=0):
  - Word: replaces all 4 lanes.
  - Half: writes Data_in[15:0] into the addressed half.
  - Byte: writes Data_in[7:0] into the addressed byte.
  - Other lanes are unchanged.
  - LED: same lane merge applied to the low SW_W bits; upper bits are ignored and read back as 0.
  - SW: stores ignored.
  - CYCLE: any aligned store of any width clears the counter.
- Misaligned store (mem_w=1, any region):
  - No state is written.
  - misalign_o is set.
  - If misalign_o was 0, bad_addr_o captures Addr_in; later misaligned stores do not overwrite it.
  - Cleared only by reset.
- Switch path: sw_i passes through a 2-flop synchroniser; SW reads return the second flop, zero-extended.
- CYCLE: increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
- RAM contents are not cleared by reset; the initial contents are undefined and can be preloaded by the bench.

## Timing
- Load latency 0: Data_out is a function of Addr_in, dm_ctrl and the current state in the same cycle.
- Store commit happens at the rising edge where mem_w=1.
- A store and a load of the same address in the same cycle: Data_out shows the old value. The new value is visible from the next cycle.
- Reset values: led_o=0, misalign_o=0, bad_addr_o=0, CYCLE=0, synchroniser flops=0.
- While reset=1:
  - all stores, including RAM stores, are suppressed;
  - CYCLE holds 0;
  - Data_out still decodes combinationally.
- CYCLE read in the first cycle after reset deasserts = 0, next cycle = 1.
- CYCLE store and increment in the same cycle: clear wins, so the next cycle reads 0, then 1.
- Switch latency: a change on sw_i is visible on SW reads 2 edges later.
- First misaligned store: misalign_o and bad_addr_o update at the same edge as the attempted store.

## Test plan
- Store word 0x8899AABB to 0x10, then load it back. Required: word -> 0x8899AABB; byte signed @0x11 -> 0xFFFFFFAA; byte unsigned @0x11 -> 0x000000AA; half signed @0x12 -> 0xFFFF8899; half unsigned @0x12 -> 0x00008899.
- Starting from word 0x8899AABB @0x10: store byte 0x55 @0x13, then half 0x1234 @0x10. Required: word @0x10 reads 0x55991234.
- Store word @0x22 (misaligned), then store half @0x31. Required: word @0x20 unchanged; misalign_o=1; bad_addr_o=0x00000022, still 0x22 after the second store; reset clears both.
- Store 0xFFFFABCD to 0xFFFF0000 (SW_W=16). Required: led_o=0xABCD; read returns 0x0000ABCD. Then byte store 0x12 @0xFFFF0001. Required: led_o=0x12CD.
- Deassert reset and read CYCLE over 5 cycles. Required: 0,1,2,3,4. Then store to 0xFFFF0008. Required: next read 0, then 1.
- Set sw_i=0x00F0. Required: SW read at 0xFFFF0004 still returns the previous value after 1 edge and 0x000000F0 after 2 edges. Unmapped read @0x8000_0000 -> 0.
